// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and latency constants for the EX-stage
// multiply/divide unit.
package muldiv_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam int MD_WIDTH   = 32;
    localparam int MD_LATENCY = MD_WIDTH + 2;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_iterative(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers with one-bit-per-cycle shift-add multiply,
// restoring divide and the final sign correction of the result.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             div_op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   orig_a;
    logic               sign_a;
    logic               sign_b;
    logic               div_mode;

    logic               neg_a;
    logic               neg_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    assign neg_a = signed_op & srca[WIDTH-1];
    assign neg_b = signed_op & srcb[WIDTH-1];

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_mag} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        diff     = {1'b0, rem_sh} - {2'b00, b_mag};
        if (diff[WIDTH+1])
            div_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            b_mag    <= '0;
            orig_a   <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc      <= {{WIDTH{1'b0}}, (neg_a ? -srca : srca)};
            b_mag    <= neg_b ? -srcb : srcb;
            orig_a   <= srca;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            div_mode <= div_op;
        end else if (step) begin
            acc <= div_mode ? div_next : mul_next;
        end
    end

    // Divide by zero bypasses the sign fixup so hi returns the untouched dividend
    always_comb begin
        prod = (sign_a ^ sign_b) ? -acc : acc;
        quot = acc[WIDTH-1:0];
        rem  = acc[2*WIDTH-1:WIDTH];
        if (!div_mode) begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_mag == '0) begin
            res_hi = orig_a;
            res_lo = '1;
        end else begin
            res_hi = sign_a ? -rem : rem;
            res_lo = (sign_a ^ sign_b) ? -quot : quot;
        end
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide unit: FSM, iteration counter, architectural
// HI/LO registers and the registered busy/done handshake to the hazard unit.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e        state;
    md_state_e        state_next;
    logic [CW-1:0]    count;
    logic             start_md;
    logic             count_last;
    logic             load;
    logic             step;
    logic             fix;
    logic             mthi_we;
    logic             mtlo_we;
    logic             busy_next;
    logic             done_next;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;

    assign start_md   = start && is_iterative(op);
    assign count_last = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (reset)
            state <= MD_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            MD_IDLE: if (start_md) state_next = MD_RUN;
            MD_RUN:  if (count_last) state_next = MD_FIX;
            MD_FIX:  state_next = MD_IDLE;
            default: state_next = MD_IDLE;
        endcase
    end

    // Starts of any kind are only honoured in IDLE; the hazard unit stalls otherwise
    always_comb begin
        load      = (state == MD_IDLE) && start_md;
        step      = (state == MD_RUN);
        fix       = (state == MD_FIX);
        mthi_we   = (state == MD_IDLE) && start && (op == MD_MTHI);
        mtlo_we   = (state == MD_IDLE) && start && (op == MD_MTLO);
        busy_next = (state_next != MD_IDLE);
        done_next = fix;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            busy <= busy_next;
            done <= done_next;
            if (load)
                count <= '0;
            else if (step)
                count <= count + CW'(1);
            if (fix) begin
                hi <= res_hi;
                lo <= res_lo;
            end else begin
                if (mthi_we) hi <= srca;
                if (mtlo_we) lo <= srca;
            end
        end
    end

    muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .step      (step),
        .div_op    ((op == MD_DIV) || (op == MD_DIVU)),
        .signed_op ((op == MD_MULT) || (op == MD_DIV)),
        .srca      (srca),
        .srcb      (srcb),
        .res_hi    (res_hi),
        .res_lo    (res_lo)
    );

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed testbench for ex_muldiv: table of mul/div vectors with hand-computed
// results, plus sequences for reset abort, ignored starts and MTHI/MTLO.
module tb_ex_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    ex_muldiv #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .srca  (srca),
        .srcb  (srcb),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Issue one op at the negedge, release start right after the sampling edge
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = MD_NONE;
    endtask

    // Count busy cycles until done is seen; returns in the done cycle (sampled #1 after edge)
    task automatic waitDone(output int busy_cycles, output logic timed_out);
        busy_cycles = 0;
        timed_out   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            if (busy) busy_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int   bc;
        logic to;

        vecs[0] = '{"mult_neg3x7",    MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{"multu_max",      MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2] = '{"divu_100_7",     MD_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
        vecs[3] = '{"div_neg7_2",     MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4] = '{"div_ovf",        MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{"divu_by_zero",   MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
        vecs[6] = '{"mult_after_dz",  MD_MULT,  32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A};
        vecs[7] = '{"div_7_neg2",     MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[8] = '{"multu_2_31x2",   MD_MULTU, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000};

        reset = 1'b1;
        start = 1'b0;
        op    = MD_NONE;
        srca  = '0;
        srcb  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Each next op is issued in the previous op's done cycle (back-to-back)
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, "_busy_start"}, {31'd0, busy}, 32'd1);
            checkOutput({vecs[i].name, "_done_start"}, {31'd0, done}, 32'd0);
            waitDone(bc, to);
            checkOutput({vecs[i].name, "_timeout"}, {31'd0, to}, 32'd0);
            checkOutput({vecs[i].name, "_busy_cycles"}, bc, 32'd33);
            checkOutput({vecs[i].name, "_busy_done"}, {31'd0, busy}, 32'd0);
            checkOutput({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            checkOutput({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
        end
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);

        // Reset during a divide aborts it without a done pulse
        applyStimulus(MD_DIV, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        to = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) to = 1'b1;
        end
        checkOutput("abort_no_done", {31'd0, to}, 32'd0);

        // MTHI while busy must be ignored
        applyStimulus(MD_MULT, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        applyStimulus(MD_MTHI, 32'h0000AAAA, 32'd0);
        waitDone(bc, to);
        checkOutput("ign_timeout", {31'd0, to}, 32'd0);
        checkOutput("ign_hi", hi, 32'd0);
        checkOutput("ign_lo", lo, 32'd15);

        // MTHI/MTLO when idle: one cycle, no busy, no done
        @(posedge clk);
        #1;
        applyStimulus(MD_MTHI, 32'h00001111, 32'd0);
        checkOutput("mthi_hi", hi, 32'h00001111);
        checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
        applyStimulus(MD_MTLO, 32'h00000055, 32'd0);
        checkOutput("mtlo_lo", lo, 32'h00000055);
        checkOutput("mtlo_hi", hi, 32'h00001111);
        checkOutput("mtlo_done", {31'd0, done}, 32'd0);
        checkOutput("mtlo_busy", {31'd0, busy}, 32'd0);

        // Undefined op 7 has no effect
        applyStimulus(3'd7, 32'hDEADBEEF, 32'd1);
        checkOutput("op7_busy", {31'd0, busy}, 32'd0);
        checkOutput("op7_hi", hi, 32'h00001111);
        checkOutput("op7_lo", lo, 32'h00000055);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
